// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory bus (req/gnt/rvalid) plus the fetch-to-decode valid/ready handshake.
interface if_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding imem request at a time, result held for decode,
// pc_en pulsed when decode accepts the instruction.
module if_fetch_ctrl #(
  parameter logic [31:0] PC_RESET_VALUE = 32'h0,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [31:0]    curr_pc,
  output logic           pc_en,
  input  logic           halt,
  input  logic           flush,
  if_fetch_ctrl_if.master bus,
  output logic           fetch_err
);

  // state  | meaning
  // IDLE   | latch curr_pc and start a fetch unless halted/flushed
  // REQ    | imem_req high until granted
  // WAIT   | granted, waiting for rvalid (dropped if killed)
  // HOLD   | instruction presented to decode until accepted or flushed
  // ERR    | bus timeout, parked until flush
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t      r_state, w_next;
  logic        r_kill, w_kill;
  logic [31:0] r_addr, w_addr;
  logic [31:0] r_iout, w_iout;
  logic [31:0] r_ipc, w_ipc;
  logic [31:0] r_cnt, w_cnt;
  logic [31:0] w_cnt_inc;
  logic        w_tmo;
  logic        w_pc_en;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
  assign w_tmo     = TMO_EN && (r_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_kill  <= 1'b0;
      r_addr  <= PC_RESET_VALUE;
      r_iout  <= NOP_INSTR;
      r_ipc   <= PC_RESET_VALUE;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_next;
      r_kill  <= w_kill;
      r_addr  <= w_addr;
      r_iout  <= w_iout;
      r_ipc   <= w_ipc;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_kill  = r_kill;
    w_addr  = r_addr;
    w_iout  = r_iout;
    w_ipc   = r_ipc;
    w_cnt   = r_cnt;
    w_pc_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_iout = NOP_INSTR;
        end else if (!halt) begin
          w_addr = curr_pc;
          w_cnt  = 32'd0;
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        w_cnt = w_cnt_inc;
        if (flush) w_kill = 1'b1;
        if (bus.imem_gnt)  w_next = S_WAIT;
        else if (w_tmo)    w_next = S_ERR;
      end
      S_WAIT: begin
        w_cnt = w_cnt_inc;
        if (bus.imem_rvalid) begin
          // A flush arriving together with the data kills it just like an earlier one.
          if (r_kill || flush) begin
            w_kill = 1'b0;
            w_next = S_IDLE;
          end else begin
            w_iout = bus.imem_rdata;
            w_ipc  = r_addr;
            w_next = S_HOLD;
          end
        end else begin
          if (flush) w_kill = 1'b1;
          if (w_tmo) w_next = S_ERR;
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_iout = NOP_INSTR;
          w_next = S_IDLE;
        end else if (bus.instr_ready) begin
          w_pc_en = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_ERR: begin
        // Clear any pending kill so the first fetch after recovery is not discarded.
        if (flush) begin
          w_kill = 1'b0;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign pc_en           = w_pc_en;
  assign fetch_err       = (r_state == S_ERR);
  assign bus.imem_req    = (r_state == S_REQ);
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = (r_state == S_HOLD);
  assign bus.instr_out   = r_iout;
  assign bus.instr_pc    = r_ipc;

endmodule
